// File: rtl/bios_sram_arbiter.sv
// Single-port arbiter for the next186 8-bit SRAM bus: HPS BIOS loader vs core port, plus BIOS-load reset sequencing.
// Optional feature macro: BIOS_CHECKSUM_EN (16-bit running sum of loaded BIOS bytes on bios_sum).
//
// state     | meaning
// ----------+--------------------------------------------------------------
// ST_IDLE   | bus quiet; pick loader buffer first, then an unblocked core request
// ST_SETUP  | address/data driven, write enable still high
// ST_STROBE | ACCESS_CYCLES cycles; we_n low for writes, read data captured on the last one
// ST_HOLD   | we_n high, address/data stable; core ack or loader buffer release
module bios_sram_arbiter #(
   parameter logic [15:0] BIOS_INDEX    = 16'd0,
   parameter logic [20:0] BIOS_BASE     = 21'h1F0000,
   parameter int unsigned ACCESS_CYCLES = 3,
   parameter int unsigned RESET_HOLD    = 16
) (
   input  logic        clk_sys,
   input  logic        reset_n,
   input  logic        ioctl_download,
   input  logic [15:0] ioctl_index,
   input  logic        ioctl_wr,
   input  logic [24:0] ioctl_addr,
   input  logic [7:0]  ioctl_dout,
   output logic        ioctl_wait,
   input  logic        core_req,
   input  logic        core_we,
   input  logic [20:0] core_addr,
   input  logic [7:0]  core_wdata,
   output logic [7:0]  core_rdata,
   output logic        core_ack,
   output logic        core_reset,
   output logic        bios_loaded,
   output logic [20:0] sram_a,
   output logic [7:0]  sram_dout,
   input  logic [7:0]  sram_din,
   output logic        sram_oe,
   output logic        sram_we_n,
   output logic [15:0] bios_sum
);

   typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD} state_t;

   localparam logic [3:0] ACC_LD  = 4'(ACCESS_CYCLES);
   localparam logic [7:0] HOLD_LD = 8'(RESET_HOLD);

   state_t      state_q, state_d;
   logic [3:0]  strobe_cnt_q, strobe_cnt_d;
   logic        is_wr_q, is_wr_d;
   logic        is_ldr_q, is_ldr_d;
   logic [20:0] sram_a_q, sram_a_d;
   logic [7:0]  sram_dout_q, sram_dout_d;
   logic [7:0]  rdata_q, rdata_d;
   logic        buf_full_q, buf_full_d;
   logic [20:0] buf_addr_q, buf_addr_d;
   logic [7:0]  buf_data_q, buf_data_d;
   logic        dl_q, dl_d;
   logic        done_pend_q, done_pend_d;
   logic        loaded_q, loaded_d;
   logic        core_rst_q, core_rst_d;
   logic [7:0]  hold_cnt_q, hold_cnt_d;
   logic        hold_act_q, hold_act_d;

   logic qual, dl_start, dl_end, core_block, ldr_clr, accept;
   logic unused_addr_hi;

   // Upper download offset bits are deliberately discarded before the base add.
   assign unused_addr_hi = ^ioctl_addr[24:21];

`ifdef BIOS_CHECKSUM_EN
   logic [15:0] sum_q, sum_d;
`endif

   always_comb begin
      qual       = ioctl_download && (ioctl_index == BIOS_INDEX);
      dl_start   = qual && !dl_q;
      dl_end     = !qual && dl_q;
      core_block = qual || core_rst_q;
      ldr_clr    = (state_q == ST_HOLD) && is_ldr_q;
      accept     = ioctl_wr && qual && (!buf_full_q || ldr_clr);

      state_d      = state_q;
      strobe_cnt_d = strobe_cnt_q;
      is_wr_d      = is_wr_q;
      is_ldr_d     = is_ldr_q;
      sram_a_d     = sram_a_q;
      sram_dout_d  = sram_dout_q;
      rdata_d      = rdata_q;
      buf_full_d   = buf_full_q;
      buf_addr_d   = buf_addr_q;
      buf_data_d   = buf_data_q;
      dl_d         = qual;
      done_pend_d  = done_pend_q;
      loaded_d     = loaded_q;
      core_rst_d   = core_rst_q;
      hold_cnt_d   = hold_cnt_q;
      hold_act_d   = hold_act_q;
`ifdef BIOS_CHECKSUM_EN
      sum_d        = sum_q;
`endif

      case (state_q)
         ST_IDLE: begin
            if (buf_full_q) begin
               state_d     = ST_SETUP;
               is_wr_d     = 1'b1;
               is_ldr_d    = 1'b1;
               sram_a_d    = buf_addr_q;
               sram_dout_d = buf_data_q;
            end else if (core_req && !core_block) begin
               state_d     = ST_SETUP;
               is_wr_d     = core_we;
               is_ldr_d    = 1'b0;
               sram_a_d    = core_addr;
               sram_dout_d = core_wdata;
            end
         end
         ST_SETUP: begin
            state_d      = ST_STROBE;
            strobe_cnt_d = ACC_LD;
         end
         ST_STROBE: begin
            if (strobe_cnt_q == 4'd1) begin
               state_d = ST_HOLD;
               if (!is_wr_q) rdata_d = sram_din;
            end else begin
               strobe_cnt_d = strobe_cnt_q - 4'd1;
            end
         end
         ST_HOLD: begin
            state_d = ST_IDLE;
            if (is_ldr_q) begin
               buf_full_d = 1'b0;
`ifdef BIOS_CHECKSUM_EN
               if (!loaded_q) sum_d = sum_q + {8'h00, sram_dout_q};
`endif
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // A new byte arriving as the loader HOLD frees the buffer takes the slot.
      if (accept) begin
         buf_full_d = 1'b1;
         buf_addr_d = BIOS_BASE + ioctl_addr[20:0];
         buf_data_d = ioctl_dout;
      end

      if (dl_start) begin
         loaded_d    = 1'b0;
         core_rst_d  = 1'b1;
         done_pend_d = 1'b0;
         hold_act_d  = 1'b0;
`ifdef BIOS_CHECKSUM_EN
         sum_d       = 16'h0000;
`endif
      end else begin
         if (dl_end) done_pend_d = 1'b1;
         if (done_pend_q && !buf_full_q && (state_q == ST_IDLE)) begin
            done_pend_d = 1'b0;
            loaded_d    = 1'b1;
            hold_cnt_d  = HOLD_LD;
            hold_act_d  = 1'b1;
         end else if (hold_act_q) begin
            if (hold_cnt_q == 8'd1) begin
               hold_cnt_d = 8'd0;
               hold_act_d = 1'b0;
               core_rst_d = 1'b0;
            end else begin
               hold_cnt_d = hold_cnt_q - 8'd1;
            end
         end
      end
   end

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= ST_IDLE;
         strobe_cnt_q <= 4'd0;
         is_wr_q      <= 1'b0;
         is_ldr_q     <= 1'b0;
         sram_a_q     <= 21'd0;
         sram_dout_q  <= 8'd0;
         rdata_q      <= 8'd0;
         buf_full_q   <= 1'b0;
         buf_addr_q   <= 21'd0;
         buf_data_q   <= 8'd0;
         dl_q         <= 1'b0;
         done_pend_q  <= 1'b0;
         loaded_q     <= 1'b0;
         core_rst_q   <= 1'b1;
         hold_cnt_q   <= 8'd0;
         hold_act_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         strobe_cnt_q <= strobe_cnt_d;
         is_wr_q      <= is_wr_d;
         is_ldr_q     <= is_ldr_d;
         sram_a_q     <= sram_a_d;
         sram_dout_q  <= sram_dout_d;
         rdata_q      <= rdata_d;
         buf_full_q   <= buf_full_d;
         buf_addr_q   <= buf_addr_d;
         buf_data_q   <= buf_data_d;
         dl_q         <= dl_d;
         done_pend_q  <= done_pend_d;
         loaded_q     <= loaded_d;
         core_rst_q   <= core_rst_d;
         hold_cnt_q   <= hold_cnt_d;
         hold_act_q   <= hold_act_d;
      end
   end

`ifdef BIOS_CHECKSUM_EN
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) sum_q <= 16'h0000;
      else          sum_q <= sum_d;
   end
   assign bios_sum = sum_q;
`else
   assign bios_sum = 16'h0000;
`endif

   // Strobe decode comes straight from state so reset releases we_n without a clock.
   assign sram_we_n   = !((state_q == ST_STROBE) && is_wr_q);
   assign sram_oe     = is_wr_q && (state_q != ST_IDLE);
   assign sram_a      = sram_a_q;
   assign sram_dout   = sram_dout_q;
   assign core_ack    = (state_q == ST_HOLD) && !is_ldr_q;
   assign core_rdata  = rdata_q;
   assign ioctl_wait  = buf_full_q;
   assign core_reset  = core_rst_q;
   assign bios_loaded = loaded_q;

endmodule
